sha_mmio_controller: RTL and testbench
======================================

Name: sha_mmio_controller

Overview:
- Parametrised memory-mapped bridge between the 16-bit CPU bus and a SHA compression core.
- CPU writes a multi-word message into an internal word buffer; the block applies SHA-style padding (0x80 marker, zero fill, 64-bit bit-length) and presents one padded block to the core.
- Block then runs a start/wait handshake, latches the digest and serves it back as auto-incrementing bus words.
- Single-block messages only; sits at a decoded window in the bus address map.

Parameters:
BASE_ADDR, 12'h030, address[15:4] match value for this block's 16-register window
DATA_W, 16, bus data width and message word width
BLOCK_W, 512, padded block width presented to core
HASH_W, 256, digest width from core
MAX_WORDS (local), (BLOCK_W-64-DATA_W)/DATA_W = 27, message word capacity

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
address  in  16  bus address
rw  in  1  1=read, 0=write
strobe  in  1  one-cycle bus access qualifier
datain  in  DATA_W  bus write data
dataout  out  DATA_W  bus read data, registered
hash  in  HASH_W  core digest
done  in  1  core completion level
block  out  BLOCK_W  padded block to core, registered
start  out  1  one-cycle core start pulse
core_reset  out  1  one-cycle core soft-reset pulse
irq  out  1  level, high while done_flag set

Behaviour:
- Access valid only when strobe=1 and address[15:4]=BASE_ADDR. Offsets: 0 CTRL/STATUS, 1 MSG_DATA (write), 2 HASH_DATA (read), 3 PTR_CLR (write any value). Other offsets: reads return 0, writes ignored.
- Reset (reset_n=0, async): dataout=0, block=0, start=0, core_reset=0, irq=0; word count=0, hash read index=0, done_flag=0, ovf=0, busy=0, digest register=0, state IDLE. Reset mid-hash abandons operation.
- Read latency 1 cycle: dataout updates on the edge after the strobe and holds until the next valid read.
- STATUS read: bit0 done_flag, bit1 busy, bit2 ovf, bits[12:8] word count, other bits 0.
- CTRL write 1: soft reset. core_reset=1 for one cycle; clears buffer, count, ovf, done_flag, hash index; state to IDLE from any state. Takes priority over a simultaneous done.
- CTRL write 2: start. Accepted only in IDLE with ovf=0; otherwise ignored. Other CTRL values ignored.
- MSG_DATA write: accepted only in IDLE. Stores the word at index=count, count+1, clears done_flag. At count=MAX_WORDS the word is dropped, ovf=1 and count saturates.
- PTR_CLR: in IDLE, count=0, ovf=0 and hash index=0. Ignored when busy.
- States:
  - IDLE: waits for a start command.
  - LOAD: one cycle. Builds block.
    - word i at block[BLOCK_W-1-DATA_W*i -: DATA_W] for i<count.
    - word at index count = {1'b1, zeros}.
    - remaining bits zero.
    - block[63:0] = count*DATA_W, unsigned, zero-extended.
    - busy=1.
  - FIRE: start=1 for exactly this cycle.
  - WAIT: exits on a rising edge of done, sampled against done registered in WAIT. A done already high on entry is not taken as completion.
  - CAPTURE: digest register <= hash, done_flag=1, busy=0, hash index=0, then back to IDLE.
- Start-to-core latency: start asserts 2 cycles after the CTRL write edge.
- block holds its value after LOAD until the next LOAD or a reset.
- HASH_DATA read: returns digest[HASH_W-1-DATA_W*k -: DATA_W] (MSB word first), then k+1. Wraps to 0 after HASH_W/DATA_W-1. Reads while busy return 0 and do not advance the index.
- Buffer contents are retained after a hash; count is cleared by PTR_CLR or soft reset.
- irq = done_flag, registered.

Test Plan:
- Empty message: reset, CTRL=2 -> start pulses 2 cycles later. block = 0x8000 followed by zeros, block[63:0]=0. Drive a done rising edge -> STATUS=0x0001 (busy clear, done set), irq=1.
- Single word 0x6162: write MSG_DATA, CTRL=2 -> block[511:480]=0x6162_8000, block[63:0]=16, STATUS during WAIT bit1=1.
- Hash readback: hash=256'h0123..., complete a run, then 17 reads of HASH_DATA -> words 0x0123 onward MSB first, 17th read wraps to word 0.
- Overflow: 28 MSG_DATA writes -> STATUS bits[12:8]=27, ovf=1. CTRL=2 ignored (start stays 0). PTR_CLR -> ovf=0, count=0.
- Stale done: hold done=1 before start -> no completion until done falls then rises. Write MSG_DATA during WAIT -> count unchanged.
- Soft reset mid-WAIT with simultaneous done rise -> core_reset pulses, state IDLE, done_flag=0. Assert reset_n=0 asynchronously mid-FIRE -> start drops immediately, all outputs 0.

Source files
------------

// File: rtl/sha_mmio_controller_if.sv
// CPU-side bus bundle for the SHA MMIO bridge: one-cycle strobed accesses
// with a registered read-data return.
interface sha_mmio_controller_if #(
   parameter int unsigned DATA_W = 16
) ();
   logic [15:0]       address;
   logic              rw;
   logic              strobe;
   logic [DATA_W-1:0] datain;
   logic [DATA_W-1:0] dataout;

   modport master (output address, output rw, output strobe, output datain, input dataout);
   modport slave  (input address, input rw, input strobe, input datain, output dataout);
endinterface

// File: rtl/sha_mmio_controller.sv
// Memory-mapped bridge that buffers a message, pads it into one SHA block,
// runs a start/done handshake with the core and serves the digest back.
module sha_mmio_controller #(
   parameter logic [11:0] BASE_ADDR = 12'h030,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned BLOCK_W   = 512,
   parameter int unsigned HASH_W    = 256
) (
   input  logic                 clk,
   input  logic                 reset_n,
   sha_mmio_controller_if.slave bus,
   input  logic [HASH_W-1:0]    hash,
   input  logic                 done,
   output logic [BLOCK_W-1:0]   block,
   output logic                 start,
   output logic                 core_reset,
   output logic                 irq
);
   localparam int unsigned MAX_WORDS = (BLOCK_W - 64 - DATA_W) / DATA_W;
   localparam int unsigned CNT_W     = $clog2(MAX_WORDS + 1);
   localparam int unsigned HWORDS    = HASH_W / DATA_W;
   localparam int unsigned HIDX_W    = $clog2(HWORDS);

   localparam logic [3:0] OFF_CTRL = 4'd0;
   localparam logic [3:0] OFF_MSG  = 4'd1;
   localparam logic [3:0] OFF_HASH = 4'd2;
   localparam logic [3:0] OFF_PTR  = 4'd3;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_FIRE = 3'd2;
   localparam logic [2:0] S_WAIT = 3'd3;
   localparam logic [2:0] S_CAPT = 3'd4;

   logic [2:0]          state, state_d;
   logic [CNT_W-1:0]    count, count_d;
   logic [HIDX_W-1:0]   hidx, hidx_d;
   logic                ovf, ovf_d;
   logic                busy, busy_d;
   logic                done_flag, done_flag_d;
   logic                done_q;
   logic [HASH_W-1:0]   digest, digest_d;
   logic [BLOCK_W-1:0]  block_d;
   logic [DATA_W-1:0]   dataout_d;
   logic                start_d, core_reset_d;
   logic                buf_we, buf_clr;
   logic [DATA_W-1:0]   msg_buf [MAX_WORDS];
   logic [BLOCK_W-1:0]  padded;
   logic [DATA_W-1:0]   status;
   logic [DATA_W-1:0]   hash_word;
   logic                hit, rd, wr;
   logic [3:0]          offset;

   assign hit    = bus.strobe && (bus.address[15:4] == BASE_ADDR);
   assign rd     = hit && bus.rw;
   assign wr     = hit && !bus.rw;
   assign offset = bus.address[3:0];

   assign status    = DATA_W'({5'(count), 5'b0, ovf, busy, done_flag});
   assign hash_word = digest[HASH_W-1-DATA_W*int'(hidx) -: DATA_W];

   // Padded block: stored words, 0x80 marker word, zero fill, 64-bit bit length.
   always_comb begin
      padded = '0;
      for (int i = 0; i < int'(MAX_WORDS); i++) begin
         if (i < int'(count)) padded[BLOCK_W-1-DATA_W*i -: DATA_W] = msg_buf[i];
      end
      padded[BLOCK_W-1-DATA_W*int'(count) -: DATA_W] = {1'b1, {(DATA_W-1){1'b0}}};
      padded[63:0] = 64'(count) * 64'(DATA_W);
   end

   // State register and all registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         count       <= '0;
         hidx        <= '0;
         ovf         <= 1'b0;
         busy        <= 1'b0;
         done_flag   <= 1'b0;
         done_q      <= 1'b0;
         digest      <= '0;
         block       <= '0;
         bus.dataout <= '0;
         start       <= 1'b0;
         core_reset  <= 1'b0;
         irq         <= 1'b0;
      end else begin
         state       <= state_d;
         count       <= count_d;
         hidx        <= hidx_d;
         ovf         <= ovf_d;
         busy        <= busy_d;
         done_flag   <= done_flag_d;
         done_q      <= done;
         digest      <= digest_d;
         block       <= block_d;
         bus.dataout <= dataout_d;
         start       <= start_d;
         core_reset  <= core_reset_d;
         irq         <= done_flag_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(MAX_WORDS); i++) msg_buf[i] <= '0;
      end else if (buf_clr) begin
         for (int i = 0; i < int'(MAX_WORDS); i++) msg_buf[i] <= '0;
      end else if (buf_we) begin
         msg_buf[count] <= bus.datain;
      end
   end

   // Next-state and next-output logic; soft reset is applied last so it wins.
   always_comb begin
      state_d      = state;
      count_d      = count;
      hidx_d       = hidx;
      ovf_d        = ovf;
      busy_d       = busy;
      done_flag_d  = done_flag;
      digest_d     = digest;
      block_d      = block;
      dataout_d    = bus.dataout;
      start_d      = 1'b0;
      core_reset_d = 1'b0;
      buf_we       = 1'b0;
      buf_clr      = 1'b0;

      if (rd) begin
         case (offset)
            OFF_CTRL: dataout_d = status;
            OFF_HASH: begin
               if (busy) begin
                  dataout_d = '0;
               end else begin
                  dataout_d = hash_word;
                  hidx_d    = (hidx == HIDX_W'(HWORDS - 1)) ? '0 : hidx + HIDX_W'(1);
               end
            end
            default:  dataout_d = '0;
         endcase
      end

      case (state)
         S_IDLE: begin
            if (wr) begin
               case (offset)
                  OFF_MSG: begin
                     done_flag_d = 1'b0;
                     if (count == CNT_W'(MAX_WORDS)) begin
                        ovf_d = 1'b1;
                     end else begin
                        buf_we  = 1'b1;
                        count_d = count + CNT_W'(1);
                     end
                  end
                  OFF_PTR: begin
                     count_d = '0;
                     ovf_d   = 1'b0;
                     hidx_d  = '0;
                  end
                  OFF_CTRL: begin
                     if (bus.datain == DATA_W'(2) && !ovf) state_d = S_LOAD;
                  end
                  default: ;
               endcase
            end
         end
         S_LOAD: begin
            block_d = padded;
            busy_d  = 1'b1;
            state_d = S_FIRE;
         end
         S_FIRE: begin
            start_d = 1'b1;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // A done level already present on entry is not a completion.
            if (done && !done_q) state_d = S_CAPT;
         end
         S_CAPT: begin
            digest_d    = hash;
            done_flag_d = 1'b1;
            busy_d      = 1'b0;
            hidx_d      = '0;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (wr && offset == OFF_CTRL && bus.datain == DATA_W'(1)) begin
         core_reset_d = 1'b1;
         buf_clr      = 1'b1;
         count_d      = '0;
         ovf_d        = 1'b0;
         done_flag_d  = 1'b0;
         hidx_d       = '0;
         busy_d       = 1'b0;
         start_d      = 1'b0;
         state_d      = S_IDLE;
      end
   end
endmodule

// File: tb/tb_sha_mmio_controller.sv
// Self-checking bench for sha_mmio_controller: directed scenarios plus randomized
// messages and digests checked against a queue-based reference model.
module tb_sha_mmio_controller;
   localparam int unsigned DATA_W  = 16;
   localparam int unsigned BLOCK_W = 512;
   localparam int unsigned HASH_W  = 256;
   localparam int unsigned MAXW    = 27;
   localparam logic [15:0] BASE    = 16'h0300;

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic [HASH_W-1:0]  hash = '0;
   logic               done = 1'b0;
   logic [BLOCK_W-1:0] block;
   logic               start, core_reset, irq;

   int tests = 0;
   int fails = 0;

   // Reference model state
   logic [15:0]       mq[$];
   bit                m_ovf, m_done;
   logic [HASH_W-1:0] m_dig;
   int                m_hidx;

   sha_mmio_controller_if #(.DATA_W(DATA_W)) bus ();

   sha_mmio_controller #(.BASE_ADDR(12'h030), .DATA_W(DATA_W), .BLOCK_W(BLOCK_W), .HASH_W(HASH_W)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus), .hash(hash), .done(done),
      .block(block), .start(start), .core_reset(core_reset), .irq(irq));

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout tests=%0d", tests);
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [BLOCK_W-1:0] obs, input logic [BLOCK_W-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [3:0] off, input logic [15:0] d);
      @(negedge clk);
      bus.address = BASE | 16'(off);
      bus.rw = 1'b0; bus.datain = d; bus.strobe = 1'b1;
      @(negedge clk);
      bus.strobe = 1'b0;
   endtask

   task automatic bus_read(input logic [3:0] off, output logic [15:0] d);
      @(negedge clk);
      bus.address = BASE | 16'(off);
      bus.rw = 1'b1; bus.strobe = 1'b1;
      @(negedge clk);
      bus.strobe = 1'b0;
      d = bus.dataout;
   endtask

   function automatic logic [15:0] exp_status(input bit busy);
      int v;
      v = mq.size() * 256 + (m_ovf ? 4 : 0) + (busy ? 2 : 0) + (m_done ? 1 : 0);
      return 16'(v);
   endfunction

   // Message words shifted in, then the marker, then aligned to the top; length last.
   function automatic logic [BLOCK_W-1:0] exp_block();
      logic [BLOCK_W-1:0] v;
      v = '0;
      foreach (mq[i]) v = (v << 16) | BLOCK_W'(mq[i]);
      v = (v << 16) | BLOCK_W'(16'h8000);
      v = v << (BLOCK_W - 16 * (mq.size() + 1));
      v[63:0] = 64'(mq.size() * 16);
      return v;
   endfunction

   task automatic m_msg(input logic [15:0] w);
      m_done = 1'b0;
      if (mq.size() == MAXW) m_ovf = 1'b1;
      else mq.push_back(w);
      bus_write(4'd1, w);
   endtask

   task automatic m_ptrclr();
      mq.delete(); m_ovf = 1'b0; m_hidx = 0;
      bus_write(4'd3, 16'h0);
   endtask

   task automatic check_status(input string tag, input bit busy);
      logic [15:0] d;
      bus_read(4'd0, d);
      check(tag, BLOCK_W'(d), BLOCK_W'(exp_status(busy)));
   endtask

   task automatic check_hash_reads(input string tag, input int n);
      logic [15:0] d;
      logic [HASH_W-1:0] sh;
      for (int i = 0; i < n; i++) begin
         bus_read(4'd2, d);
         sh = m_dig >> (HASH_W - 16 * (m_hidx + 1));
         check(tag, BLOCK_W'(d), BLOCK_W'(sh[15:0]));
         m_hidx = (m_hidx + 1) % 16;
      end
   endtask

   // Issue start and check the pulse lands 2 cycles after the write edge, for one cycle.
   task automatic start_run(input string tag);
      bus_write(4'd0, 16'h0002);
      check({tag, "_start_n1"}, BLOCK_W'(start), '0);
      @(negedge clk);
      check({tag, "_start_n2"}, BLOCK_W'(start), '0);
      @(negedge clk);
      check({tag, "_start_n3"}, BLOCK_W'(start), BLOCK_W'(1));
      @(negedge clk);
      check({tag, "_start_n4"}, BLOCK_W'(start), '0);
      check({tag, "_block"}, block, exp_block());
   endtask

   task automatic finish_run(input string tag, input logic [HASH_W-1:0] h);
      hash = h;
      done = 1'b0;
      @(negedge clk);
      done = 1'b1;
      repeat (3) @(negedge clk);
      done = 1'b0;
      m_dig = h; m_done = 1'b1; m_hidx = 0;
      check({tag, "_irq"}, BLOCK_W'(irq), BLOCK_W'(1));
      check_status({tag, "_status"}, 1'b0);
   endtask

   function automatic logic [HASH_W-1:0] rand_hash();
      logic [HASH_W-1:0] h;
      for (int i = 0; i < 8; i++) h = (h << 32) | HASH_W'($urandom);
      return h;
   endfunction

   initial begin
      logic [15:0] d;
      int n;
      bus.address = '0; bus.rw = 1'b0; bus.strobe = 1'b0; bus.datain = '0;
      mq.delete(); m_ovf = 0; m_done = 0; m_dig = '0; m_hidx = 0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      // Reset state
      check("rst_dataout", BLOCK_W'(bus.dataout), '0);
      check("rst_block", block, '0);
      check("rst_start", BLOCK_W'(start), '0);
      check("rst_core_reset", BLOCK_W'(core_reset), '0);
      check("rst_irq", BLOCK_W'(irq), '0);
      check_status("rst_status", 1'b0);

      // Empty message
      start_run("empty");
      check("empty_block_lit", block, {16'h8000, 496'h0});
      finish_run("empty", '0);
      bus_read(4'd0, d);
      check("empty_status_lit", BLOCK_W'(d), BLOCK_W'(16'h0001));

      // Single word plus busy-time reads
      m_ptrclr();
      m_msg(16'h6162);
      start_run("one");
      check("one_top32", BLOCK_W'(block[511:480]), BLOCK_W'(32'h6162_8000));
      check("one_len", BLOCK_W'(block[63:0]), BLOCK_W'(64'd16));
      bus_read(4'd0, d);
      check("one_busy_bit", BLOCK_W'(d[1]), BLOCK_W'(1));
      bus_read(4'd2, d);
      check("one_hash_busy", BLOCK_W'(d), '0);
      bus_read(4'd5, d);
      check("unmapped_read", BLOCK_W'(d), '0);
      finish_run("one", 256'h0123_4567_89ab_cdef_fedc_ba98_7654_3210_1111_2222_3333_4444_5555_6666_7777_8888);

      // Digest readback with wrap on the 17th read
      check_hash_reads("hash_rd", 17);

      // Overflow: 28 writes, start refused, PTR_CLR recovers
      m_ptrclr();
      for (int i = 0; i < 28; i++) m_msg(16'($urandom));
      check_status("ovf_status", 1'b0);
      bus_write(4'd0, 16'h0002);
      for (int i = 0; i < 4; i++) begin
         check("ovf_no_start", BLOCK_W'(start), '0);
         @(negedge clk);
      end
      m_ptrclr();
      check_status("ovf_cleared", 1'b0);

      // Stale done level, and MSG writes ignored during WAIT
      m_msg(16'hbeef);
      done = 1'b1;
      start_run("stale");
      repeat (4) @(negedge clk);
      check_status("stale_still_busy", 1'b1);
      bus_write(4'd1, 16'h1234);
      check_status("wait_msg_ignored", 1'b1);
      finish_run("stale", rand_hash());
      check_hash_reads("stale_hash", 2);

      // Soft reset mid-WAIT with a simultaneous done rise
      start_run("srst");
      @(negedge clk);
      bus.address = BASE; bus.rw = 1'b0; bus.datain = 16'h0001; bus.strobe = 1'b1;
      done = 1'b1;
      @(negedge clk);
      bus.strobe = 1'b0;
      check("srst_core_reset_hi", BLOCK_W'(core_reset), BLOCK_W'(1));
      @(negedge clk);
      check("srst_core_reset_lo", BLOCK_W'(core_reset), '0);
      done = 1'b0;
      mq.delete(); m_ovf = 0; m_done = 0; m_hidx = 0;
      check("srst_irq", BLOCK_W'(irq), '0);
      check_status("srst_status", 1'b0);

      // Randomized messages and digests
      for (int it = 0; it < 5; it++) begin
         m_ptrclr();
         n = (it == 4) ? int'(MAXW) : int'($urandom_range(0, MAXW));
         for (int i = 0; i < n; i++) m_msg(16'($urandom));
         check_status("rnd_status", 1'b0);
         start_run("rnd");
         finish_run("rnd", rand_hash());
         check_hash_reads("rnd_hash", 16 + it);
      end

      // Asynchronous reset while start is high
      m_ptrclr();
      m_msg(16'h00aa);
      check_status("pre_areset_status", 1'b0);
      bus_write(4'd0, 16'h0002);
      repeat (2) @(negedge clk);
      check("areset_start_hi", BLOCK_W'(start), BLOCK_W'(1));
      #1 reset_n = 1'b0;
      #1;
      check("areset_start", BLOCK_W'(start), '0);
      check("areset_block", block, '0);
      check("areset_dataout", BLOCK_W'(bus.dataout), '0);
      check("areset_irq", BLOCK_W'(irq), '0);
      check("areset_core_reset", BLOCK_W'(core_reset), '0);
      @(negedge clk);
      reset_n = 1'b1;
      mq.delete(); m_ovf = 0; m_done = 0; m_dig = '0; m_hidx = 0;
      check_status("post_areset_status", 1'b0);
      check_hash_reads("post_areset_hash", 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
